// File: rtl/fft_pingpong_out_buf.sv
// Ping-pong frame buffer between FFT result writes and a valid/ready sample stream.
// The writer fills one N-entry bank in any order while the reader drains the other, naturally or bit-reversed.
module fft_pingpong_out_buf #(
  parameter int DW    = 32,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             wr_commit,
  output logic             wr_rdy,
  input  logic             rd_bitrev,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [1:0]       frames_pending
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  logic [DW-1:0]    mem [2*N];
  logic [DW-1:0]    rd_data_q;

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_active_q, rd_active_d;
  logic             frame_bitrev_q, frame_bitrev_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_pend_last_q, rd_pend_last_d;
  logic [DW-1:0]    skid_data_q [2];
  logic [DW-1:0]    skid_data_d [2];
  logic [1:0]       skid_last_q, skid_last_d;
  logic             skid_head_q, skid_head_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;

  logic             wr_fire, commit_fire, pop, space, start, issue, release_buf, use_rev, skid_tail;
  logic [1:0]       skid_after;
  logic [LOG2N-1:0] cur_cnt, cnt_rev, rd_addr;

  assign wr_rdy         = !full_q[wr_sel_q];
  assign wr_fire        = rstn && wr_en && wr_rdy;
  assign commit_fire    = wr_commit && wr_rdy;
  assign out_vld        = (skid_cnt_q != 2'd0);
  assign out_data       = skid_data_q[skid_head_q];
  assign out_last       = skid_last_q[skid_head_q];
  assign frames_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign pop            = out_vld && out_rdy;

  // Skid occupancy after this edge, counting the read already in flight; a new read is
  // issued only if its data is guaranteed a slot when it arrives next cycle.
  assign skid_after = skid_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign space      = !skid_after[1];

  // Starting a frame also issues index 0, so frames follow each other without a bubble.
  assign start       = !rd_active_q && full_q[rd_sel_q] && space;
  assign issue       = start || (rd_active_q && space);
  assign release_buf = issue && rd_active_q && (rd_cnt_q == LAST_IDX);
  assign cur_cnt     = rd_active_q ? rd_cnt_q : '0;
  assign use_rev     = rd_active_q ? frame_bitrev_q : rd_bitrev;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_rev
      assign cnt_rev[gi] = cur_cnt[LOG2N-1-gi];
    end
  endgenerate

  assign rd_addr   = use_rev ? cnt_rev : cur_cnt;
  assign skid_tail = skid_head_q ^ skid_cnt_q[0];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_sel_q, wr_addr}] <= wr_data;
    rd_data_q <= mem[{rd_sel_q, rd_addr}];
  end

  always_comb begin
    wr_sel_d       = wr_sel_q ^ commit_fire;
    rd_sel_d       = rd_sel_q ^ release_buf;
    full_d         = full_q;
    if (release_buf) full_d[rd_sel_q] = 1'b0;
    if (commit_fire) full_d[wr_sel_q] = 1'b1;

    rd_active_d    = rd_active_q;
    rd_cnt_d       = rd_cnt_q;
    frame_bitrev_d = frame_bitrev_q;
    if (start) begin
      rd_active_d    = 1'b1;
      frame_bitrev_d = rd_bitrev;
      rd_cnt_d       = LOG2N'(1);
    end else if (release_buf) begin
      rd_active_d    = 1'b0;
      rd_cnt_d       = '0;
    end else if (issue) begin
      rd_cnt_d       = rd_cnt_q + 1'b1;
    end
    rd_pend_d      = issue;
    rd_pend_last_d = release_buf;

    skid_data_d    = skid_data_q;
    skid_last_d    = skid_last_q;
    skid_head_d    = skid_head_q ^ pop;
    skid_cnt_d     = skid_after;
    if (rd_pend_q) begin
      skid_data_d[skid_tail] = rd_data_q;
      skid_last_d[skid_tail] = rd_pend_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_sel_q       <= 1'b0;
      rd_sel_q       <= 1'b0;
      full_q         <= 2'b00;
      rd_cnt_q       <= '0;
      rd_active_q    <= 1'b0;
      frame_bitrev_q <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_last_q    <= 2'b00;
      skid_head_q    <= 1'b0;
      skid_cnt_q     <= 2'd0;
    end else begin
      wr_sel_q       <= wr_sel_d;
      rd_sel_q       <= rd_sel_d;
      full_q         <= full_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_active_q    <= rd_active_d;
      frame_bitrev_q <= frame_bitrev_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
      skid_data_q    <= skid_data_d;
      skid_last_q    <= skid_last_d;
      skid_head_q    <= skid_head_d;
      skid_cnt_q     <= skid_cnt_d;
    end
  end
endmodule

// File: tb/tb_fft_pingpong_out_buf.sv
// Randomised scoreboard bench for the ping-pong output buffer (N=8 instance plus an N=32, 16-bit instance).
`timescale 1ns/1ps
module tb_fft_pingpong_out_buf;
  localparam int DW = 32, LOG2N = 3, N = 8;
  localparam int BDW = 16, BLOG2N = 5, BN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0, wr_en = 1'b0, wr_commit = 1'b0, rd_bitrev = 1'b0, out_rdy = 1'b0;
  logic [LOG2N-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0, out_data;
  logic wr_rdy, out_vld, out_last;
  logic [1:0] frames_pending;

  logic b_rstn = 1'b0, b_wr_en = 1'b0, b_wr_commit = 1'b0, b_bitrev = 1'b0, b_rdy = 1'b0;
  logic [BLOG2N-1:0] b_wr_addr = '0;
  logic [BDW-1:0] b_wr_data = '0, b_data;
  logic b_wr_rdy, b_vld, b_last;
  logic [1:0] b_pending;

  fft_pingpong_out_buf #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_rdy(wr_rdy), .rd_bitrev(rd_bitrev), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last), .frames_pending(frames_pending));

  fft_pingpong_out_buf #(.DW(BDW), .LOG2N(BLOG2N)) dut_big (
    .clk(clk), .rstn(b_rstn), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_commit(b_wr_commit), .wr_rdy(b_wr_rdy), .rd_bitrev(b_bitrev), .out_vld(b_vld),
    .out_rdy(b_rdy), .out_data(b_data), .out_last(b_last), .frames_pending(b_pending));

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_d[$];
  bit exp_l[$];
  logic [DW-1:0] seen[$];
  int seen_cyc[$];
  int committed = 0, done_frames = 0, cyc = 0, rdy_mode = 0;
  logic [DW-1:0] frame_buf[N];
  logic [BDW-1:0] b_exp_d[$];
  bit b_exp_l[$];
  int b_xfers = 0, b_lasts = 0;

  function automatic int bit_rev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (((v >> i) & 1) != 0) r |= 1 << (bits - 1 - i);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Expected drain of a committed frame: natural or bit-reversed index order.
  task automatic model_commit;
    for (int i = 0; i < N; i++) begin
      exp_d.push_back(frame_buf[rd_bitrev ? bit_rev(i, LOG2N) : i]);
      exp_l.push_back(i == N - 1);
    end
    committed++;
  endtask

  task automatic send_frame(input bit rnd);
    int perm[N];
    int n, j, tmp;
    bit commit_last;
    n = 0;
    while (!wr_rdy && n < 400) begin tick(); n++; end
    check("wr_rdy_wait", 64'(wr_rdy), 64'd1);
    for (int i = 0; i < N; i++) perm[i] = i;
    if (rnd) begin
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      wr_en = 1'b1; wr_commit = 1'b0;
      wr_addr = LOG2N'($urandom_range(N - 1));
      wr_data = 32'hBAD0_0000 | 32'($urandom_range(255));
      tick();
    end
    commit_last = rnd ? 1'($urandom_range(1)) : 1'b1;
    for (int k = 0; k < N; k++) begin
      if (rnd && $urandom_range(3) == 0) begin wr_en = 1'b0; wr_commit = 1'b0; tick(); end
      wr_en = 1'b1;
      wr_addr = LOG2N'(perm[k]);
      wr_data = frame_buf[perm[k]];
      wr_commit = (k == N - 1) && commit_last;
      tick();
    end
    if (!commit_last) begin wr_en = 1'b0; wr_commit = 1'b1; tick(); end
    wr_en = 1'b0; wr_commit = 1'b0;
    model_commit();
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((exp_d.size() != 0 || frames_pending != 2'd0) && n < 2000) begin tick(); n++; end
    checks++;
    if (exp_d.size() != 0 || frames_pending != 2'd0) begin
      errors++;
      $display("FAIL drain: %0d samples outstanding, pending %0d, required 0 and 0", exp_d.size(), frames_pending);
    end
    repeat (3) tick();
  endtask

  initial begin
    forever begin
      tick();
      case (rdy_mode)
        0: out_rdy = 1'b0;
        1: out_rdy = 1'b1;
        default: out_rdy = 1'($urandom_range(1));
      endcase
    end
  end

  // Every-cycle comparison of the N=8 instance against the model.
  initial begin
    logic prev_vld, prev_rdy, prev_last, el;
    logic [DW-1:0] prev_data, ed;
    int fo;
    prev_vld = 1'b0; prev_rdy = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        prev_vld = 1'b0;
      end else begin
        checks++;
        if (wr_rdy !== (frames_pending != 2'd2)) begin
          errors++;
          $display("FAIL wr_rdy_vs_pending: wr_rdy %0b with pending %0d", wr_rdy, frames_pending);
        end
        fo = committed - done_frames;
        checks++;
        if (!(int'(frames_pending) <= fo && int'(frames_pending) + 1 >= fo)) begin
          errors++;
          $display("FAIL pending: got %0d, required %0d or %0d", frames_pending, fo, fo - 1);
        end
        if (prev_vld && !prev_rdy) begin
          checks++;
          if (out_vld !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: got vld %0b data 0x%0h last %0b, required 1 0x%0h %0b",
                     out_vld, out_data, out_last, prev_data, prev_last);
          end
        end
        if (out_vld && out_rdy) begin
          checks++;
          if (exp_d.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got 0x%0h, required no output", out_data);
          end else begin
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            if (out_data !== ed || out_last !== el) begin
              errors++;
              $display("FAIL sample: got 0x%0h last %0b, required 0x%0h last %0b", out_data, out_last, ed, el);
            end
            if (el) done_frames++;
          end
          seen.push_back(out_data);
          seen_cyc.push_back(cyc);
        end
        prev_vld = out_vld; prev_rdy = out_rdy; prev_data = out_data; prev_last = out_last;
      end
    end
  end

  // Comparison for the N=32 instance: scoreboard, last every 32nd, no gap once streaming.
  initial begin
    logic [BDW-1:0] ed;
    bit el;
    forever begin
      @(negedge clk);
      if (b_rstn) begin
        if (b_xfers > 0 && b_xfers < 4 * BN) begin
          checks++;
          if (!b_vld) begin
            errors++;
            $display("FAIL big_gap: out_vld 0 after %0d transfers, required 1", b_xfers);
          end
        end
        if (b_vld && b_rdy) begin
          checks++;
          if (b_exp_d.size() == 0) begin
            errors++;
            $display("FAIL big_unexpected: got 0x%0h, required no output", b_data);
          end else begin
            ed = b_exp_d.pop_front();
            el = b_exp_l.pop_front();
            if (b_data !== ed || b_last !== el || b_last !== ((b_xfers % BN) == BN - 1)) begin
              errors++;
              $display("FAIL big_sample %0d: got 0x%0h last %0b, required 0x%0h last %0b", b_xfers, b_data, b_last, ed, el);
            end
          end
          if (b_last) b_lasts++;
          b_xfers++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit2[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int n;
    logic [BDW-1:0] bd;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_pending", 64'(frames_pending), 64'd0);
    tick();
    rstn = 1'b1; b_rstn = 1'b1;
    @(negedge clk);
    check("rst_wr_rdy", 64'(wr_rdy), 64'd1);

    // Natural order, latency and contiguity
    rdy_mode = 1;
    tick(); tick();
    seen.delete(); seen_cyc.delete();
    for (int i = 0; i < N; i++) frame_buf[i] = 32'(i);
    rd_bitrev = 1'b0;
    send_frame(1'b0);
    @(negedge clk); check("lat_edge_t", 64'(out_vld), 64'd0);
    @(negedge clk); check("lat_edge_t1", 64'(out_vld), 64'd0);
    @(negedge clk); check("lat_edge_t2", 64'(out_vld), 64'd1);
    wait_idle();
    check("nat_count", 64'(seen.size()), 64'd8);
    if (seen.size() == 8) begin
      for (int i = 0; i < N; i++) check("nat_value", 64'(seen[i]), 64'(i));
      check("nat_contiguous", 64'(seen_cyc[7] - seen_cyc[0]), 64'd7);
    end

    // Bit-reversed order, rd_bitrev toggling mid-frame
    seen.delete(); seen_cyc.delete();
    rd_bitrev = 1'b1;
    send_frame(1'b0);
    tick();
    repeat (10) begin rd_bitrev = ~rd_bitrev; tick(); end
    rd_bitrev = 1'b0;
    wait_idle();
    check("rev_count", 64'(seen.size()), 64'd8);
    if (seen.size() == 8)
      for (int i = 0; i < N; i++) check("rev_value", 64'(seen[i]), 64'(lit2[i]));

    // Two frames under backpressure, third frame ignored
    rdy_mode = 0;
    repeat (2) tick();
    seen.delete(); seen_cyc.delete();
    for (int i = 0; i < N; i++) frame_buf[i] = 32'h100 + 32'(i);
    send_frame(1'b0);
    for (int i = 0; i < N; i++) frame_buf[i] = 32'h200 + 32'(i);
    send_frame(1'b0);
    repeat (4) tick();
    check("bp_wr_rdy", 64'(wr_rdy), 64'd0);
    check("bp_pending", 64'(frames_pending), 64'd2);
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = LOG2N'(i); wr_data = 32'hDEAD_0000 + 32'(i); wr_commit = (i == N - 1);
      tick();
    end
    wr_en = 1'b0; wr_commit = 1'b0;
    check("bp_pending_after_ignored", 64'(frames_pending), 64'd2);
    rdy_mode = 1;
    wait_idle();
    check("bp_count", 64'(seen.size()), 64'd16);
    if (seen.size() == 16) begin
      check("bp_first", 64'(seen[0]), 64'h100);
      check("bp_mid", 64'(seen[8]), 64'h200);
      check("bp_final", 64'(seen[15]), 64'h207);
      check("bp_contiguous", 64'(seen_cyc[15] - seen_cyc[0]), 64'd15);
    end
    check("bp_wr_rdy_back", 64'(wr_rdy), 64'd1);

    // Random data, random write order, random out_rdy
    rdy_mode = 2;
    for (int b = 0; b < 4; b++) begin
      rd_bitrev = 1'(b & 1);
      for (int f = 0; f < 5; f++) begin
        for (int i = 0; i < N; i++) frame_buf[i] = $urandom;
        send_frame(1'b1);
      end
      wait_idle();
    end
    rd_bitrev = 1'b0;

    // Reset mid-frame
    rdy_mode = 1;
    tick(); tick();
    seen.delete(); seen_cyc.delete();
    for (int i = 0; i < N; i++) frame_buf[i] = 32'h500 + 32'(i);
    send_frame(1'b0);
    n = 0;
    while (seen.size() < 3 && n < 100) begin tick(); n++; end
    check("rst_mid_reached", 64'(seen.size()), 64'd3);
    rstn = 1'b0;
    tick();
    exp_d.delete(); exp_l.delete();
    committed = 0; done_frames = 0;
    @(negedge clk);
    check("rst_mid_vld", 64'(out_vld), 64'd0);
    check("rst_mid_pending", 64'(frames_pending), 64'd0);
    check("rst_mid_wr_rdy", 64'(wr_rdy), 64'd1);
    tick();
    rstn = 1'b1;
    repeat (5) begin @(negedge clk); check("rst_quiet_vld", 64'(out_vld), 64'd0); end
    tick();
    seen.delete(); seen_cyc.delete();
    for (int i = 0; i < N; i++) frame_buf[i] = 32'h600 + 32'(i);
    send_frame(1'b0);
    wait_idle();
    check("rst_fresh_count", 64'(seen.size()), 64'd8);
    if (seen.size() == 8) check("rst_fresh_first", 64'(seen[0]), 64'h600);

    // N=32, 16-bit instance with back-to-back frames
    b_rdy = 1'b1;
    tick();
    for (int f = 0; f < 4; f++) begin
      check("big_wr_rdy", 64'(b_wr_rdy), 64'd1);
      for (int i = 0; i < BN; i++) begin
        bd = BDW'($urandom);
        b_wr_en = 1'b1; b_wr_addr = BLOG2N'(i); b_wr_data = bd; b_wr_commit = (i == BN - 1);
        b_exp_d.push_back(bd);
        b_exp_l.push_back(i == BN - 1);
        tick();
      end
    end
    b_wr_en = 1'b0; b_wr_commit = 1'b0;
    n = 0;
    while (b_xfers < 4 * BN && n < 400) begin tick(); n++; end
    repeat (3) tick();
    check("big_xfers", 64'(b_xfers), 64'(4 * BN));
    check("big_lasts", 64'(b_lasts), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
